store_write_buffer: RTL and testbench

//  Posted-write buffer between the store formatter and the data-memory bus.
//  - Accepts byte-lane-replicated store data plus byte enables from the store formatter.
//  - Queues up to DEPTH stores and drains them in order over a valid/ready bus.
//  - Stalls loads that could read stale memory.
//  - Serialises FENCE with a drain state machine.

---
 rtl/store_write_buffer_pkg.sv | 20 ++
 rtl/store_write_buffer_fifo.sv | 67 ++++++
 rtl/store_write_buffer.sv | 130 +++++++++++++
 tb/tb_store_write_buffer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared configuration for the store write buffer: default depth, address width,
// fence FSM states and the queued entry layout.
package store_write_buffer_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned WBUF_AW    = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } wbuf_state_t;

    typedef struct packed {
        logic [WBUF_AW-1:2] addr;
        logic [31:0]        data;
        logic [3:0]         be;
    } wbuf_entry_t;

endpackage

// File: rtl/store_write_buffer_fifo.sv
// Entry storage for the store write buffer: circular array, wrap-bit pointers,
// occupancy count and full/empty flags. Slot contents are exported when
// WBUF_LOAD_BYPASS_EN is defined so the top level can match load addresses.
module wbuf_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  wbuf_entry_t              wr_entry,
    output wbuf_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
`ifdef WBUF_LOAD_BYPASS_EN
    ,
    output wbuf_entry_t              slots [DEPTH],
    output logic [DEPTH-1:0]         occupied
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    wbuf_entry_t   mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wr_entry;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

`ifdef WBUF_LOAD_BYPASS_EN
    logic [PW-1:0] offset;

    assign slots = mem;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        occupied = '0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - rd_ptr[PW-1:0];
            occupied[i] = ({1'b0, offset} < count);
        end
    end
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the store formatter and the data-memory bus, with
// fence drain FSM and load stall. Define WBUF_LOAD_BYPASS_EN for address-matched stalls.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH,
    parameter int unsigned AW    = WBUF_AW
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    iStoreValid,
    input  logic [AW-1:0]           iStoreAddress,
    input  logic [31:0]             iStoreData,
    input  logic [3:0]              iStoreByteEn,
    output logic                    oStoreReady,
    output logic                    oMisaligned,
    input  logic                    iLoadValid,
    input  logic [AW-1:0]           iLoadAddress,
    output logic                    oLoadStall,
    input  logic                    iFence,
    output logic                    oFenceDone,
    output logic                    oMemWrite,
    output logic [AW-1:0]           oMemAddress,
    output logic [31:0]             oMemData,
    output logic [3:0]              oMemByteEn,
    input  logic                    iMemReady,
    output logic [$clog2(DEPTH):0]  oCount,
    output logic                    oEmpty,
    output logic                    oFull
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wbuf_state_t  state;
    wbuf_state_t  state_next;
    wbuf_entry_t  wr_entry;
    wbuf_entry_t  head;
    logic         store_take;
    logic         fifo_push;
    logic         fifo_pop;
    logic         misaligned_q;

`ifdef WBUF_LOAD_BYPASS_EN
    wbuf_entry_t      slots [DEPTH];
    logic [DEPTH-1:0] occupied;
`endif

    assign wr_entry.addr = iStoreAddress[AW-1:2];
    assign wr_entry.data = iStoreData;
    assign wr_entry.be   = iStoreByteEn;

    assign oStoreReady = !oFull && (state == ST_RUN);
    assign store_take  = iStoreValid && oStoreReady;
    assign fifo_push   = store_take && (iStoreByteEn != '0);
    assign fifo_pop    = oMemWrite && iMemReady;

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (iCLK),
        .rst_n    (iRST_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (oCount),
        .empty    (oEmpty),
        .full     (oFull)
`ifdef WBUF_LOAD_BYPASS_EN
        ,
        .slots    (slots),
        .occupied (occupied)
`endif
    );

    // Bus outputs are a pure function of occupancy so oMemWrite never sees iMemReady.
    assign oMemWrite   = !oEmpty;
    assign oMemAddress = oEmpty ? '0 : {head.addr, 2'b00};
    assign oMemData    = oEmpty ? '0 : head.data;
    assign oMemByteEn  = oEmpty ? '0 : head.be;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= ST_RUN;
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_next;
            misaligned_q <= store_take && (iStoreByteEn == '0);
        end
    end

    assign oMisaligned = misaligned_q;
    assign oFenceDone  = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                // A store accepted alongside the fence edge still has to drain.
                if (iFence) state_next = (oEmpty && !fifo_push) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (oEmpty || (fifo_pop && oCount == CW'(1))) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

`ifdef WBUF_LOAD_BYPASS_EN
    logic load_hit;
    logic unused_bits;

    always_comb begin
        load_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (slots[i].addr == iLoadAddress[AW-1:2])) load_hit = 1'b1;
        end
    end

    assign oLoadStall  = iLoadValid && load_hit;
    assign unused_bits = ^{iStoreAddress[1:0], iLoadAddress[1:0]};
`else
    logic unused_bits;

    assign oLoadStall  = iLoadValid && !oEmpty;
    assign unused_bits = ^{iStoreAddress[1:0], iLoadAddress};
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: scoreboard of expected bus writes
// against writes observed on the memory bus, plus per-scenario flag checks.
module tb_store_write_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_valid;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic        store_ready;
    logic        misaligned;
    logic        load_valid;
    logic [31:0] load_addr;
    logic        load_stall;
    logic        fence;
    logic        fence_done;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int vectors = 0;
    int miscompares = 0;

    txn_t exp_q[$];
    txn_t seen_q[$];

`ifdef WBUF_LOAD_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    store_write_buffer #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .iCLK          (clk),
        .iRST_n        (rst_n),
        .iStoreValid   (store_valid),
        .iStoreAddress (store_addr),
        .iStoreData    (store_data),
        .iStoreByteEn  (store_be),
        .oStoreReady   (store_ready),
        .oMisaligned   (misaligned),
        .iLoadValid    (load_valid),
        .iLoadAddress  (load_addr),
        .oLoadStall    (load_stall),
        .iFence        (fence),
        .oFenceDone    (fence_done),
        .oMemWrite     (mem_write),
        .oMemAddress   (mem_addr),
        .oMemData      (mem_data),
        .oMemByteEn    (mem_be),
        .iMemReady     (mem_ready),
        .oCount        (count),
        .oEmpty        (empty),
        .oFull         (full)
    );

    always #5 clk = ~clk;

    // Record every bus handshake; the pop happens at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && mem_write && mem_ready) seen_q.push_back('{mem_addr, mem_data, mem_be});
    end

    always @(posedge clk) begin
        if (rst_n) assert (!(store_valid && load_valid)) else $error("store and load requested together");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one store from just after a rising edge; returns once accepted (or timed out).
    task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                             output logic ok);
        ok          = 1'b0;
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_be    = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (store_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok && b != 4'b0000) exp_q.push_back('{{a[31:2], 2'b00}, d, b});
        @(posedge clk);
        #1;
        store_valid = 1'b0;
    endtask

    task automatic wait_empty(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        store_valid = 1'b0;
        store_addr  = '0;
        store_data  = '0;
        store_be    = '0;
        load_valid  = 1'b0;
        load_addr   = '0;
        fence       = 1'b0;
        mem_ready   = 1'b0;
        #3;
        vectors++;
        if ({empty, full, count, mem_write} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_flags: empty/full/count/write=%b/%b/%0d/%b want 1/0/0/0", empty, full, count, mem_write);
        end
        vectors++;
        if ({mem_addr, mem_data, mem_be, misaligned, fence_done} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h data=%h be=%b mis=%b done=%b want all zero", mem_addr, mem_data, mem_be, misaligned, fence_done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (store_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: store_ready=%b want 1", store_ready);
        end
    endtask

    task automatic check_scoreboard(input string tag);
        while (exp_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            vectors++;
            if (seen_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s_missing: no bus write, want addr=%h data=%h be=%b", tag, e.addr, e.data, e.be);
            end else begin
                txn_t s = seen_q.pop_front();
                if ({s.addr, s.data, s.be} !== {e.addr, e.data, e.be}) begin
                    miscompares++;
                    $display("FAIL %s_order: got addr=%h data=%h be=%b want addr=%h data=%h be=%b",
                             tag, s.addr, s.data, s.be, e.addr, e.data, e.be);
                end
            end
        end
        vectors++;
        if (seen_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_extra: %0d unexpected bus writes, want 0", tag, seen_q.size());
            seen_q.delete();
        end
    endtask

    task automatic test_single_store;
        logic ok;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        put_store(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_accept: store not accepted, want accepted");
        end
        @(negedge clk);
        vectors++;
        if ({mem_write, mem_addr, mem_data, mem_be} !== {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111}) begin
            miscompares++;
            $display("FAIL single_head: write=%b addr=%h data=%h be=%b want 1 00000100 deadbeef 1111", mem_write, mem_addr, mem_data, mem_be);
        end
        @(negedge clk);
        vectors++;
        if ({empty, count} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL single_empty: empty=%b count=%0d want 1 0", empty, count);
        end
        check_scoreboard("single");
    endtask

    task automatic test_full_backpressure;
        logic ok;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_store(32'h0000_0400 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b0001 << i, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL fill_accept: store %0d not accepted, want accepted", i);
            end
        end
        @(negedge clk);
        vectors++;
        if ({full, count, store_ready} !== {1'b1, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL full_flags: full=%b count=%0d ready=%b want 1 4 0", full, count, store_ready);
        end
        @(posedge clk);
        #1;
        store_valid = 1'b1;
        store_addr  = 32'h0000_0413;
        store_data  = 32'hA000_0004;
        store_be    = 4'b1100;
        @(negedge clk);
        vectors++;
        if (store_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fifth_held: store_ready=%b want 0", store_ready);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (store_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_no_free: store_ready=%b want 0 in pop cycle", store_ready);
        end
        @(negedge clk);
        vectors++;
        if ({count, store_ready} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL after_pop: count=%0d ready=%b want 3 1", count, store_ready);
        end
        exp_q.push_back('{32'h0000_0410, 32'hA000_0004, 4'b1100});
        @(posedge clk);
        #1;
        store_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL push_pop_count: count=%0d want 3", count);
        end
        wait_empty(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL full_drain: buffer not empty within budget, want empty");
        end
        check_scoreboard("full");
    endtask

    task automatic test_misaligned;
        logic ok;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        put_store(32'h0000_0500, 32'h1122_3344, 4'b0011, ok);
        put_store(32'h0000_0202, 32'h5566_5566, 4'b0000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mis_consume: zero-enable store not consumed, want consumed");
        end
        @(negedge clk);
        vectors++;
        if ({misaligned, count} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL mis_pulse: misaligned=%b count=%0d want 1 1", misaligned, count);
        end
        @(negedge clk);
        vectors++;
        if ({misaligned, count} !== {1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL mis_clear: misaligned=%b count=%0d want 0 1", misaligned, count);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        wait_empty(ok);
        check_scoreboard("mis");
    endtask

    task automatic test_fence;
        logic ok;
        int   pops;
        int   last_pop;
        int   done_at;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_store(32'h0000_0600 + 32'(i * 8), 32'hF000_0000 + 32'(i * 17), 4'b1111, ok);
        end
        fence = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (store_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fence_ready: store_ready=%b want 0 while draining", store_ready);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        pops      = 0;
        last_pop  = -10;
        done_at   = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_write && mem_ready) begin
                pops++;
                last_pop = c;
            end
            if (fence_done) begin
                done_at = c;
                break;
            end
        end
        vectors++;
        if (pops != 3 || done_at != last_pop + 1) begin
            miscompares++;
            $display("FAIL fence_done: pops=%0d done_at=%0d last_pop=%0d want 3 pops, done one cycle after last pop", pops, done_at, last_pop);
        end
        @(posedge clk);
        #1;
        fence = 1'b0;
        @(negedge clk);
        vectors++;
        if (fence_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fence_pulse: fence_done=%b want 0 after one cycle", fence_done);
        end
        check_scoreboard("fence");
        @(posedge clk);
        #1;
        fence = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (fence_done !== 1'b1) begin
            miscompares++;
            $display("FAIL fence_empty: fence_done=%b want 1 one cycle after fence on empty buffer", fence_done);
        end
        @(posedge clk);
        #1;
        fence = 1'b0;
    endtask

    task automatic test_load_stall;
        logic ok;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        put_store(32'h0000_0300, 32'h0BAD_F00D, 4'b1111, ok);
        load_valid = 1'b1;
        load_addr  = 32'h0000_0304;
        @(negedge clk);
        vectors++;
        if (load_stall !== !BYPASS) begin
            miscompares++;
            $display("FAIL stall_other_word: stall=%b want %b", load_stall, !BYPASS);
        end
        @(posedge clk);
        #1;
        load_addr = 32'h0000_0302;
        @(negedge clk);
        vectors++;
        if (load_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_same_word: stall=%b want 1", load_stall);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        mem_ready  = 1'b1;
        wait_empty(ok);
        load_valid = 1'b1;
        load_addr  = 32'h0000_0300;
        @(negedge clk);
        vectors++;
        if (load_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_empty: stall=%b want 0", load_stall);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check_scoreboard("load");
    endtask

    task automatic test_reset_mid_drain;
        logic ok;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        put_store(32'h0000_0700, 32'h7777_0000, 4'b1111, ok);
        put_store(32'h0000_0704, 32'h7777_0001, 4'b0110, ok);
        load_valid = 1'b1;
        load_addr  = 32'h0000_0700;
        @(negedge clk);
        vectors++;
        if (load_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_prestall: stall=%b want 1", load_stall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_write, empty, count, mem_addr, load_stall} !== {1'b0, 1'b1, 3'd0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_async: write=%b empty=%b count=%0d addr=%h stall=%b want 0 1 0 00000000 0",
                     mem_write, empty, count, mem_addr, load_stall);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        load_valid = 1'b0;
        exp_q.delete();
        mem_ready  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (store_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_ready: store_ready=%b want 1", store_ready);
        end
        check_scoreboard("rst");
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_backpressure();
        test_misaligned();
        test_fence();
        test_load_stall();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
